// File: rtl/cmdproc_pkg.sv
// Frame-format constants and FSM encoding shared by the command
// receive buffer and the response serializer.
package cmdproc_pkg;
  localparam int FSM_BITS = 4;
  localparam int CMD_ADDR_BYTES = 3;
  localparam int CMD_DATA_BYTES = 4;
  localparam int RD_FLAG_BIT = 23;

  typedef enum logic [FSM_BITS-1:0] {
    IDLE,
    ADDR_2,
    ADDR_1,
    ADDR_0,
    DATA_3,
    DATA_2,
    DATA_1,
    DATA_0,
    CKSUM
  } state_t;
endpackage

// File: rtl/cmdresp_serializer_if.sv
// Response handshake plus byte stream toward the host link.
// slave: serializer side; master: executor/link side.
interface cmdresp_serializer_if;
  import cmdproc_pkg::*;

  logic [CMD_ADDR_BYTES*8-1:0] resp_addr_i;
  logic [CMD_DATA_BYTES*8-1:0] resp_data_i;
  logic resp_valid_i;
  logic resp_ready_o;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic m_axis_tlast;

  modport slave (
    input resp_addr_i,
    input resp_data_i,
    input resp_valid_i,
    output resp_ready_o,
    output m_axis_tdata,
    output m_axis_tvalid,
    input m_axis_tready,
    output m_axis_tlast
  );

  modport master (
    output resp_addr_i,
    output resp_data_i,
    output resp_valid_i,
    input resp_ready_o,
    input m_axis_tdata,
    input m_axis_tvalid,
    output m_axis_tready,
    input m_axis_tlast
  );
endinterface

// File: rtl/cmdresp_serializer.sv
// Serializes one WB response (addr, optional data) MSB-first onto
// an 8-bit stream with TLAST. CMDRESP_CHECKSUM_EN appends a sum byte.
module cmdresp_serializer
  import cmdproc_pkg::*;
#(
  parameter string WB_CLK_TYPE = "NONE",
  parameter int COUNT_BITS = 16
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  cmdresp_serializer_if.slave bus,
  output logic [COUNT_BITS-1:0] frame_count_o
);

  localparam int AW = CMD_ADDR_BYTES * 8;
  localparam int DW = CMD_DATA_BYTES * 8;

  state_t state_q, state_n, tail;
  logic [AW-1:0] addr_q, addr_n;
  logic [DW-1:0] data_q, data_n;
  logic [COUNT_BITS-1:0] count_q;
  logic accept, xfer, ready, last_n;
  logic [7:0] byte_n;

  (* CUSTOM_CC_SRC = WB_CLK_TYPE *) logic [7:0] tdata_q;
  (* CUSTOM_CC_SRC = WB_CLK_TYPE *) logic tvalid_q;
  (* CUSTOM_CC_SRC = WB_CLK_TYPE *) logic tlast_q;

`ifdef CMDRESP_CHECKSUM_EN
  logic [7:0] sum_q, sum_n;
`endif

  always_comb begin
    xfer = tvalid_q && bus.m_axis_tready;
    ready = (state_q == IDLE) || (tlast_q && bus.m_axis_tready);
    accept = bus.resp_valid_i && ready;
    addr_n = accept ? bus.resp_addr_i : addr_q;
    data_n = accept ? bus.resp_data_i : data_q;
`ifdef CMDRESP_CHECKSUM_EN
    tail = CKSUM;
    sum_n = accept ? 8'h00 : (xfer ? sum_q + tdata_q : sum_q);
`else
    tail = IDLE;
`endif
    state_n = state_q;
    if (accept) begin
      state_n = ADDR_2;
    end else if (xfer) begin
      unique case (state_q)
        ADDR_2: state_n = ADDR_1;
        ADDR_1: state_n = ADDR_0;
        ADDR_0: state_n = addr_q[RD_FLAG_BIT] ? DATA_3 : tail;
        DATA_3: state_n = DATA_2;
        DATA_2: state_n = DATA_1;
        DATA_1: state_n = DATA_0;
        DATA_0: state_n = tail;
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are precomputed from the next state so they are registered.
  always_comb begin
    byte_n = 8'h00;
    unique case (state_n)
      ADDR_2: byte_n = addr_n[23:16];
      ADDR_1: byte_n = addr_n[15:8];
      ADDR_0: byte_n = addr_n[7:0];
      DATA_3: byte_n = data_n[31:24];
      DATA_2: byte_n = data_n[23:16];
      DATA_1: byte_n = data_n[15:8];
      DATA_0: byte_n = data_n[7:0];
`ifdef CMDRESP_CHECKSUM_EN
      CKSUM: byte_n = sum_n;
`endif
      default: byte_n = 8'h00;
    endcase
`ifdef CMDRESP_CHECKSUM_EN
    last_n = (state_n == CKSUM);
`else
    last_n = (state_n == DATA_0) ||
             (state_n == ADDR_0 && !addr_n[RD_FLAG_BIT]);
`endif
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      tdata_q <= 8'h00;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_n;
      addr_q <= addr_n;
      data_q <= data_n;
      tdata_q <= byte_n;
      tvalid_q <= (state_n != IDLE);
      tlast_q <= last_n;
      if (xfer && tlast_q)
        count_q <= count_q + COUNT_BITS'(1);
    end
  end

`ifdef CMDRESP_CHECKSUM_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      sum_q <= 8'h00;
    else
      sum_q <= sum_n;
  end
`endif

  assign bus.resp_ready_o = ready;
  assign bus.m_axis_tdata = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast = tlast_q;
  assign frame_count_o = count_q;

endmodule

// File: tb/tb_cmdresp_serializer.sv
// Directed + randomized bench for cmdresp_serializer with a
// byte-queue reference model; honours CMDRESP_CHECKSUM_EN.
module tb_cmdresp_serializer;
  localparam int CB = 4;
`ifdef CMDRESP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  typedef struct {
    logic [7:0] b;
    bit l;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CB-1:0] count;
  cmdresp_serializer_if bus();

  cmdresp_serializer #(
    .WB_CLK_TYPE("NONE"),
    .COUNT_BITS(CB)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus),
    .frame_count_o(count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rnd = 1'b0;
  ent_t q[$];
  logic [7:0] got[$];
  int xc[$];
  logic [CB-1:0] exp_count = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void push_frame(logic [23:0] a, logic [31:0] d);
    logic [55:0] w = {a, d};
    int n = a[23] ? 7 : 3;
    logic [7:0] s = 8'h00;
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e.b = w[55-8*i -: 8];
      e.l = (i == n - 1) && (CK == 0);
      s = s + e.b;
      q.push_back(e);
    end
    if (CK == 1) begin
      e.b = s;
      e.l = 1'b1;
      q.push_back(e);
    end
  endfunction

  // Reference monitor: q[0] is always the byte that must be on the bus.
  always @(negedge clk) begin
    cyc++;
    chk("tvalid", 32'(bus.m_axis_tvalid), 32'(q.size() != 0));
    chk("resp_ready", 32'(bus.resp_ready_o),
        32'((q.size() == 0) || (q.size() == 1 && bus.m_axis_tready)));
    chk("count", 32'(count), 32'(exp_count));
    if (q.size() != 0) begin
      chk("tdata", 32'(bus.m_axis_tdata), 32'(q[0].b));
      chk("tlast", 32'(bus.m_axis_tlast), 32'(q[0].l));
      if (bus.m_axis_tready) begin
        xc.push_back(cyc);
        got.push_back(bus.m_axis_tdata);
        if (q[0].l) exp_count++;
        void'(q.pop_front());
      end
    end
    if (bus.resp_valid_i && bus.resp_ready_o && !rst)
      push_frame(bus.resp_addr_i, bus.resp_data_i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) bus.m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(logic [23:0] a, logic [31:0] d);
    bit acc = 1'b0;
    int n = 0;
    bus.resp_addr_i = a;
    bus.resp_data_i = d;
    bus.resp_valid_i = 1'b1;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = bus.resp_ready_o;
      tick();
      n++;
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    bus.resp_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || bus.m_axis_tvalid) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("idle_timeout", 32'(n), 32'd0);
    rnd = 1'b0;
    bus.m_axis_tready = 1'b1;
  endtask

  initial begin
    logic [7:0] e1[8] = '{8'h81, 8'h23, 8'h45, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h21};
    logic [7:0] e2[4] = '{8'h01, 8'h23, 8'h45, 8'h69};
    logic [7:0] e6[4] = '{8'h01, 8'h02, 8'h03, 8'h06};
    logic [CB-1:0] c0;
    int n = 0;
    bus.resp_addr_i = '0;
    bus.resp_data_i = '0;
    bus.resp_valid_i = 1'b0;
    bus.m_axis_tready = 1'b1;
    #2;
    chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
    chk("rst_tdata", 32'(bus.m_axis_tdata), 32'd0);
    chk("rst_ready", 32'(bus.resp_ready_o), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // read response, tready high
    got.delete();
    send(24'h812345, 32'hDEADBEEF);
    chk("first_valid", 32'(bus.m_axis_tvalid), 32'd1);
    chk("first_byte", 32'(bus.m_axis_tdata), 32'h81);
    wait_idle();
    chk("rd_len", 32'(got.size()), 32'(7 + CK));
    for (int i = 0; i < 7 + CK; i++) chk("rd_byte", 32'(got[i]), 32'(e1[i]));
    chk("rd_count", 32'(count), 32'd1);

    // write ack, data must be ignored
    got.delete();
    send(24'h012345, $urandom);
    wait_idle();
    chk("wr_len", 32'(got.size()), 32'(3 + CK));
    for (int i = 0; i < 3 + CK; i++) chk("wr_byte", 32'(got[i]), 32'(e2[i]));

    // random backpressure across a read frame
    rnd = 1'b1;
    send(24'h800000 | 24'($urandom), $urandom);
    rnd = 1'b1;
    wait_idle();

    // back-to-back with tready high: no bubble
    xc.delete();
    send(24'hA1B2C3, 32'h01020304);
    send(24'h3C2B1A, 32'h55555555);
    wait_idle();
    chk("b2b_len", 32'(xc.size()), 32'(10 + 2 * CK));
    if (xc.size() != 0)
      chk("b2b_span", 32'(xc[xc.size()-1] - xc[0]), 32'(9 + 2 * CK));

    // reset while DATA_2 is presented
    send(24'h812345, 32'hDEADBEEF);
    while (q.size() != 3 + CK && n < 50) begin
      tick();
      n++;
    end
    bus.m_axis_tready = 1'b0;
    chk("d2_byte", 32'(bus.m_axis_tdata), 32'hAD);
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("arst_tlast", 32'(bus.m_axis_tlast), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    q.delete();
    exp_count = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.m_axis_tready = 1'b1;
    got.delete();
    send(24'h010203, 32'hFFFFFFFF);
    wait_idle();
    chk("post_rst_len", 32'(got.size()), 32'(3 + CK));
    for (int i = 0; i < 3 + CK; i++)
      chk("post_rst_byte", 32'(got[i]), 32'(CK == 1 ? e6[i] : e6[i]));
    chk("post_rst_count", 32'(count), 32'd1);

    // random mix, long enough to wrap the counter
    c0 = exp_count;
    for (int k = 0; k < 20; k++) begin
      rnd = 1'b1;
      send(24'($urandom), $urandom);
      if (k % 3 == 0) wait_idle();
    end
    rnd = 1'b1;
    wait_idle();
    chk("wrap_count", 32'(count), 32'(CB'(c0 + CB'(20))));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
